// File: rtl/fft_frame_collector_if.sv
// Stream-in / frame-out handshake bundle between the sample source, the collector and the FFT core.
// master drives samples and consumes frames; slave is the collector.
interface fft_frame_collector_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned N      = 32
) ();
    logic                  in_valid;
    logic [DATA_W-1:0]     in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [N*DATA_W-1:0]   out_frame;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_frame
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_frame
    );
endinterface

// File: rtl/fft_frame_collector.sv
// Serial-to-parallel frame collector feeding the 32-point FFT: two ping-pong banks so one
// fills while the other is held for the consumer.
module fft_frame_collector #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned N       = 32,
    parameter int unsigned LOG2N   = 5,
    parameter int unsigned BIT_REV = 0,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                CLK_10,
    input  logic                RST,
    input  logic                clear,
    fft_frame_collector_if.slave bus,
    output logic [CNT_W-1:0]    frame_cnt
);

    logic [LOG2N-1:0]               wr_idx_q, wr_idx_d;
    logic                           wr_bank_q, wr_bank_d;
    logic                           rd_bank_q, rd_bank_d;
    logic [1:0]                     full_q, full_d;
    logic [1:0][N*DATA_W-1:0]       bank_q, bank_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;

    logic                           in_ready;
    logic                           out_valid;
    logic                           accept;
    logic                           consume;
    logic [LOG2N-1:0]               wr_slot;

    function automatic logic [LOG2N-1:0] slot_of(input logic [LOG2N-1:0] idx);
        logic [LOG2N-1:0] r;
        r = idx;
        if (BIT_REV != 0) begin
            for (int b = 0; b < int'(LOG2N); b++) begin
                r[b] = idx[int'(LOG2N) - 1 - b];
            end
        end
        return r;
    endfunction

    assign in_ready  = ~full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    assign accept    = bus.in_valid & in_ready;
    assign consume   = out_valid & bus.out_ready;
    assign wr_slot   = slot_of(wr_idx_q);

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_frame = bank_q[rd_bank_q];
    assign frame_cnt     = cnt_q;

    always_comb begin
        wr_idx_d  = wr_idx_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        bank_d    = bank_q;
        cnt_d     = cnt_q;

        if (accept) begin
            bank_d[wr_bank_q][wr_slot*DATA_W +: DATA_W] = bus.in_data;
            if (wr_idx_q == LOG2N'(N - 1)) begin
                wr_idx_d          = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end

        // A consume never targets the bank being written: that bank is not full.
        if (consume) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            cnt_d             = cnt_q + 1'b1;
        end

        if (clear) begin
            wr_idx_d  = '0;
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
            full_d    = '0;
            bank_d    = '0;
            cnt_d     = cnt_q;
        end
    end

    always_ff @(posedge CLK_10 or negedge RST) begin
        if (!RST) begin
            wr_idx_q  <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= '0;
            bank_q    <= '0;
            cnt_q     <= '0;
        end else begin
            wr_idx_q  <= wr_idx_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            bank_q    <= bank_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fft_frame_collector.sv
// Directed bench for fft_frame_collector: a natural-order and a bit-reversed instance share stimulus.
module tb_fft_frame_collector;
    localparam int unsigned DW = 8;
    localparam int unsigned NS = 32;
    localparam int unsigned FW = NS * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic [15:0]   cnt0, cnt1;

    int n_checks = 0;
    int n_pass = 0;
    int stall_cycles = 0;

    logic [FW-1:0] frame_a, frame_b, exp_f;

    always #5 clk = ~clk;

    fft_frame_collector_if #(.DATA_W(DW), .N(NS)) bus0 ();
    fft_frame_collector_if #(.DATA_W(DW), .N(NS)) bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_data   = in_data;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_data   = in_data;
    assign bus1.out_ready = out_ready;

    fft_frame_collector #(.DATA_W(DW), .N(NS), .LOG2N(5), .BIT_REV(0), .CNT_W(16)) u_nat (
        .CLK_10    (clk),
        .RST       (rst_n),
        .clear     (clear),
        .bus       (bus0.slave),
        .frame_cnt (cnt0)
    );

    fft_frame_collector #(.DATA_W(DW), .N(NS), .LOG2N(5), .BIT_REV(1), .CNT_W(16)) u_rev (
        .CLK_10    (clk),
        .RST       (rst_n),
        .clear     (clear),
        .bus       (bus1.slave),
        .frame_cnt (cnt1)
    );

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] slot(input logic [FW-1:0] f, input int k);
        return f[k*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] t5_sample(input int f, input int k);
        return DW'(f * 37 + k * 5 + 3);
    endfunction

    // Hold one sample until it is accepted; returns at the negedge after the accepting edge.
    task automatic send(input logic [DW-1:0] s);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = s;
        while (!bus0.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) check("send_timeout", FW'(0), FW'(1));
        stall_cycles += waited;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_in_ready", FW'(bus0.in_ready), FW'(1));
        check("rst_out_valid", FW'(bus0.out_valid), FW'(0));
        check("rst_out_frame", bus0.out_frame, FW'(0));
        check("rst_frame_cnt", FW'(cnt0), FW'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Natural and bit-reversed fill of 0..31
        out_ready = 1'b1;
        for (int k = 0; k < 31; k++) send(DW'(k));
        check("t2_valid_early", FW'(bus0.out_valid), FW'(0));
        send(DW'(31));
        check("t2_valid", FW'(bus0.out_valid), FW'(1));
        for (int k = 0; k < int'(NS); k++) exp_f[k*DW +: DW] = DW'(k);
        check("t2_frame", bus0.out_frame, exp_f);
        check("t2_cnt_before", FW'(cnt0), FW'(0));
        check("t3_valid", FW'(bus1.out_valid), FW'(1));
        check("t3_slot0", FW'(slot(bus1.out_frame, 0)), FW'(0));
        check("t3_slot1", FW'(slot(bus1.out_frame, 1)), FW'(16));
        check("t3_slot2", FW'(slot(bus1.out_frame, 2)), FW'(8));
        check("t3_slot3", FW'(slot(bus1.out_frame, 3)), FW'(24));
        check("t3_slot31", FW'(slot(bus1.out_frame, 31)), FW'(31));
        @(negedge clk);
        check("t2_cnt", FW'(cnt0), FW'(1));
        check("t2_valid_drop", FW'(bus0.out_valid), FW'(0));

        // Asynchronous reset mid-fill takes effect without a clock edge
        for (int k = 0; k < 5; k++) send(DW'(8'hA0 + k));
        #2 rst_n = 1'b0;
        #1;
        check("t1_in_ready", FW'(bus0.in_ready), FW'(1));
        check("t1_out_valid", FW'(bus0.out_valid), FW'(0));
        check("t1_out_frame", bus0.out_frame, FW'(0));
        check("t1_frame_cnt", FW'(cnt0), FW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Both banks fill with consumer stalled; no sample lost
        out_ready = 1'b0;
        for (int k = 0; k < 32; k++) begin
            frame_a[k*DW +: DW] = DW'(8'h80 + k);
            frame_b[k*DW +: DW] = DW'(k + 1);
        end
        for (int k = 0; k < 32; k++) send(DW'(8'h80 + k));
        for (int k = 0; k < 32; k++) send(DW'(k + 1));
        check("t4_in_ready_full", FW'(bus0.in_ready), FW'(0));
        check("t4_frame_a", bus0.out_frame, frame_a);
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) @(negedge clk);
        check("t4_in_ready_stall", FW'(bus0.in_ready), FW'(0));
        in_valid = 1'b0;
        check("t4_frame_a_stable", bus0.out_frame, frame_a);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("t4_valid_b", FW'(bus0.out_valid), FW'(1));
        check("t4_frame_b", bus0.out_frame, frame_b);
        check("t4_cnt1", FW'(cnt0), FW'(1));
        check("t4_in_ready_free", FW'(bus0.in_ready), FW'(1));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("t4_valid_empty", FW'(bus0.out_valid), FW'(0));
        check("t4_cnt2", FW'(cnt0), FW'(2));

        // Ten back-to-back frames with a consumer that always keeps up
        out_ready    = 1'b1;
        stall_cycles = 0;
        fork
            begin
                for (int f = 0; f < 10; f++)
                    for (int k = 0; k < 32; k++) send(t5_sample(f, k));
            end
            begin
                int got = 0;
                logic [FW-1:0] e;
                for (int c = 0; c < 500 && got < 10; c++) begin
                    @(negedge clk);
                    if (bus0.out_valid) begin
                        for (int k = 0; k < 32; k++) e[k*DW +: DW] = t5_sample(got, k);
                        check($sformatf("t5_frame%0d", got), bus0.out_frame, e);
                        got++;
                    end
                end
                check("t5_frames_seen", FW'(got), FW'(10));
            end
        join
        @(negedge clk);
        check("t5_no_stall", FW'(stall_cycles), FW'(0));
        check("t5_cnt", FW'(cnt0), FW'(12));

        // Clear with one full bank and a partial frame
        out_ready = 1'b0;
        for (int k = 0; k < 32; k++) send(DW'(200 + k));
        for (int k = 0; k < 17; k++) send(DW'(k + 7));
        check("t6_valid_before", FW'(bus0.out_valid), FW'(1));
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("t6_valid_cleared", FW'(bus0.out_valid), FW'(0));
        check("t6_in_ready", FW'(bus0.in_ready), FW'(1));
        check("t6_frame_zero", bus0.out_frame, FW'(0));
        check("t6_cnt_kept", FW'(cnt0), FW'(12));
        out_ready = 1'b1;
        for (int k = 0; k < 32; k++) begin
            exp_f[k*DW +: DW] = DW'(100 + k);
            send(DW'(100 + k));
        end
        check("t6_valid", FW'(bus0.out_valid), FW'(1));
        check("t6_frame", bus0.out_frame, exp_f);
        @(negedge clk);
        check("t6_cnt", FW'(cnt0), FW'(13));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
